// File: rtl/line_queue.sv
// ----------------------------------------------------------------------------
// line_queue
// First-word-fall-through queue of line segments (two endpoints plus colour).
// The head entry is driven combinationally from storage, so a consumer sees
// valid data whenever empty is low and acknowledges it with pop.
//
// Optional error reporting is compiled in when the macro LINE_QUEUE_ERR_EN is
// defined: sticky overflow/underflow flags and a saturating drop counter,
// cleared by err_clr. Without the macro those ports and their logic are absent.
// ----------------------------------------------------------------------------
module line_queue #(
    parameter int COORD_W   = 11,
    parameter int COLOR_W   = 3,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [COORD_W-1:0]     in_start_x,
    input  logic [COORD_W-1:0]     in_start_y,
    input  logic [COORD_W-1:0]     in_end_x,
    input  logic [COORD_W-1:0]     in_end_y,
    input  logic [COLOR_W-1:0]     in_color,
    input  logic                   pop,
    input  logic                   flush,
    output logic [COORD_W-1:0]     out_start_x,
    output logic [COORD_W-1:0]     out_start_y,
    output logic [COORD_W-1:0]     out_end_x,
    output logic [COORD_W-1:0]     out_end_y,
    output logic [COLOR_W-1:0]     out_color,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count
`ifdef LINE_QUEUE_ERR_EN
    ,
    input  logic                   err_clr,
    output logic                   ovf,
    output logic                   udf,
    output logic [7:0]             drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 4 * COORD_W + COLOR_W;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rdPtr;
    logic [AW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;

    logic          w_empty;
    logic          w_full;
    logic          w_doPush;
    logic          w_doPop;
    logic [EW-1:0] w_inEntry;

    // Status decode and the accepted push/pop qualification for this cycle.
    // A push into a full queue is only accepted when a pop frees a slot, and
    // a pop of an empty queue never takes effect (even beside a push).
    always_comb begin
        w_empty   = (r_count == '0);
        w_full    = (r_count == DEPTH_C);
        w_doPush  = push && (!w_full || pop);
        w_doPop   = pop && !w_empty;
        w_inEntry = {in_start_x, in_start_y, in_end_x, in_end_y, in_color};
    end

    // Pointer and occupancy bookkeeping; flush rewinds to an empty queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Segment storage; cleared on reset so the head reads zero afterwards,
    // but left intact by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!flush && w_doPush) begin
            r_mem[r_wrPtr] <= w_inEntry;
        end
    end

    // Head entry falls through directly from storage with no read latency.
    always_comb begin
        {out_start_x, out_start_y, out_end_x, out_end_y, out_color} = r_mem[r_rdPtr];
        empty       = w_empty;
        full        = w_full;
        almost_full = (r_count >= AFULL_C);
        count       = r_count;
    end

`ifdef LINE_QUEUE_ERR_EN
    logic       r_ovf;
    logic       r_udf;
    logic [7:0] r_dropCnt;
    logic       w_dropEv;
    logic       w_udfEv;

    // Error events: a push refused because the queue is full with no pop, and
    // a lone pop of an empty queue. Flush overrides both requests, so neither
    // counts as an error in a flush cycle.
    always_comb begin
        w_dropEv = push && w_full && !pop && !flush;
        w_udfEv  = pop && w_empty && !push && !flush;
    end

    // Sticky error flags and saturating drop counter; clearing wins over a
    // simultaneous new event.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            r_dropCnt <= '0;
        end else begin
            if (w_dropEv) begin
                r_ovf <= 1'b1;
                if (r_dropCnt != 8'hFF) begin
                    r_dropCnt <= r_dropCnt + 8'd1;
                end
            end
            if (w_udfEv) begin
                r_udf <= 1'b1;
            end
        end
    end

    // Drive the error outputs from their registers.
    always_comb begin
        ovf      = r_ovf;
        udf      = r_udf;
        drop_cnt = r_dropCnt;
    end
`endif

endmodule

// File: tb/tb_line_queue.sv
// ----------------------------------------------------------------------------
// tb_line_queue
// Self-checking bench for line_queue: a table of directed vectors, a few
// hand-written multi-cycle sequences, then randomized traffic compared against
// a queue-based reference model. Error-port checks are compiled in only when
// LINE_QUEUE_ERR_EN is defined.
// ----------------------------------------------------------------------------
module tb_line_queue;

    localparam int COORD_W   = 11;
    localparam int COLOR_W   = 3;
    localparam int DEPTH     = 8;
    localparam int AFULL_LVL = DEPTH - 2;
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int EW        = 4 * COORD_W + COLOR_W;

    typedef logic [EW-1:0] entry_t;

    typedef struct {
        bit     push;
        bit     pop;
        entry_t data;
        int     expCount;
        bit     expEmpty;
        bit     expFull;
        bit     expAfull;
        int     expHeadX;
    } vec_t;

    logic               clock;
    logic               reset;
    logic               push;
    logic               pop;
    logic               flush;
    logic               errClr;
    logic [COORD_W-1:0] in_start_x, in_start_y, in_end_x, in_end_y;
    logic [COLOR_W-1:0] in_color;
    logic [COORD_W-1:0] out_start_x, out_start_y, out_end_x, out_end_y;
    logic [COLOR_W-1:0] out_color;
    logic               empty, full, almost_full;
    logic [CW-1:0]      count;
`ifdef LINE_QUEUE_ERR_EN
    logic               ovf, udf;
    logic [7:0]         drop_cnt;
`endif

    entry_t modelQ[$];
    bit     modelOvf;
    bit     modelUdf;
    int     modelDrop;

    int nChecks = 0;
    int nFails  = 0;

    vec_t vecs[$];

    line_queue #(
        .COORD_W  (COORD_W),
        .COLOR_W  (COLOR_W),
        .DEPTH    (DEPTH),
        .AFULL_LVL(AFULL_LVL)
    ) dut (
        .clk        (clock),
        .rst        (reset),
        .push       (push),
        .in_start_x (in_start_x),
        .in_start_y (in_start_y),
        .in_end_x   (in_end_x),
        .in_end_y   (in_end_y),
        .in_color   (in_color),
        .pop        (pop),
        .flush      (flush),
        .out_start_x(out_start_x),
        .out_start_y(out_start_y),
        .out_end_x  (out_end_x),
        .out_end_y  (out_end_y),
        .out_color  (out_color),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .count      (count)
`ifdef LINE_QUEUE_ERR_EN
        ,
        .err_clr    (errClr),
        .ovf        (ovf),
        .udf        (udf),
        .drop_cnt   (drop_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic entry_t mk(input int sx, input int sy, input int ex, input int ey, input int c);
        return {COORD_W'(sx), COORD_W'(sy), COORD_W'(ex), COORD_W'(ey), COLOR_W'(c)};
    endfunction

    task automatic checkVal(input string name, input longint actual, input longint expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a plain queue plus error bookkeeping, updated from the
    // inputs present at the clock edge.
    task automatic updateModel(input bit p, input bit pp, input bit f, input bit ec, input bit r, input entry_t d);
        bit wasEmpty;
        bit wasFull;
        if (r) begin
            modelQ.delete();
            modelOvf  = 0;
            modelUdf  = 0;
            modelDrop = 0;
            return;
        end
        wasEmpty = (modelQ.size() == 0);
        wasFull  = (modelQ.size() == DEPTH);
        if (f) begin
            modelQ.delete();
        end else begin
            if (pp && !wasEmpty) void'(modelQ.pop_front());
            if (p && (!wasFull || pp)) modelQ.push_back(d);
        end
        if (ec) begin
            modelOvf  = 0;
            modelUdf  = 0;
            modelDrop = 0;
        end else if (!f) begin
            if (p && wasFull && !pp) begin
                modelOvf = 1;
                if (modelDrop < 255) modelDrop++;
            end
            if (pp && wasEmpty && !p) modelUdf = 1;
        end
    endtask

    task automatic checkOutput();
        checkVal("count", longint'(count), longint'(modelQ.size()));
        checkVal("empty", longint'(empty), longint'(modelQ.size() == 0));
        checkVal("full", longint'(full), longint'(modelQ.size() == DEPTH));
        checkVal("almost_full", longint'(almost_full), longint'(modelQ.size() >= AFULL_LVL));
        if (modelQ.size() > 0) begin
            checkVal("head", longint'({out_start_x, out_start_y, out_end_x, out_end_y, out_color}),
                     longint'(modelQ[0]));
        end
`ifdef LINE_QUEUE_ERR_EN
        checkVal("ovf", longint'(ovf), longint'(modelOvf));
        checkVal("udf", longint'(udf), longint'(modelUdf));
        checkVal("drop_cnt", longint'(drop_cnt), longint'(modelDrop));
`endif
    endtask

    // One clock cycle with the given inputs, then compare against the model.
    task automatic applyStimulus(input bit p, input bit pp, input bit f, input bit ec, input bit r, input entry_t d);
        push   = p;
        pop    = pp;
        flush  = f;
        errClr = ec;
        reset  = r;
        {in_start_x, in_start_y, in_end_x, in_end_y, in_color} = d;
        @(posedge clock);
        updateModel(p, pp, f, ec, r, d);
        #1;
        checkOutput();
    endtask

    initial begin
        vec_t v;
        int   pushPct;

        push = 0; pop = 0; flush = 0; errClr = 0; reset = 1;
        {in_start_x, in_start_y, in_end_x, in_end_y, in_color} = '0;
        modelOvf = 0; modelUdf = 0; modelDrop = 0;

        // Reset state.
        applyStimulus(0, 0, 0, 0, 1, '0);
        applyStimulus(1, 1, 1, 0, 1, mk(7, 7, 7, 7, 7));
        checkVal("rstOut", longint'({out_start_x, out_start_y, out_end_x, out_end_y, out_color}), 0);
        checkVal("rstEmpty", longint'(empty), 1);
        checkVal("rstCount", longint'(count), 0);

        // Directed vector table: single push/pop, fill to full, drop, drain.
        vecs.push_back('{1, 0, mk(10, 20, 30, 40, 5), 1, 0, 0, 0, 10});
        vecs.push_back('{0, 1, '0, 0, 1, 0, 0, -1});
        for (int i = 0; i < 8; i++) begin
            vecs.push_back('{1, 0, mk(i, i + 1, i + 2, i + 3, i), i + 1, 0, (i == 7), (i + 1 >= 6), 0});
        end
        vecs.push_back('{1, 0, mk(9, 9, 9, 9, 1), 8, 0, 1, 1, 0});
        for (int k = 0; k < 8; k++) begin
            vecs.push_back('{0, 1, '0, 7 - k, (k == 7), 0, (7 - k >= 6), (k < 7) ? k + 1 : -1});
        end

        applyStimulus(0, 0, 0, 0, 0, '0);
        foreach (vecs[i]) begin
            v = vecs[i];
            applyStimulus(v.push, v.pop, 0, 0, 0, v.data);
            checkVal("vecCount", longint'(count), v.expCount);
            checkVal("vecEmpty", longint'(empty), v.expEmpty);
            checkVal("vecFull", longint'(full), v.expFull);
            checkVal("vecAfull", longint'(almost_full), v.expAfull);
            if (v.expHeadX >= 0) checkVal("vecHeadX", longint'(out_start_x), v.expHeadX);
            if (i == 0) begin
                checkVal("firstColor", longint'(out_color), 5);
                checkVal("firstEndY", longint'(out_end_y), 40);
            end
`ifdef LINE_QUEUE_ERR_EN
            if (i == 10) begin
                checkVal("dropOvf", longint'(ovf), 1);
                checkVal("dropCnt", longint'(drop_cnt), 1);
            end
`endif
        end

        // Full queue with simultaneous push and pop.
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0, mk(100 + i, 0, 0, 0, 2));
        applyStimulus(1, 1, 0, 0, 0, mk(200, 1, 2, 3, 4));
        checkVal("fullPPCount", longint'(count), 8);
`ifdef LINE_QUEUE_ERR_EN
        checkVal("fullPPOvf", longint'(ovf), 1);
        checkVal("fullPPDrop", longint'(drop_cnt), 1);
`endif
        for (int i = 0; i < 8; i++) begin
            checkVal("fullPPOrder", longint'(out_start_x), (i < 7) ? 101 + i : 200);
            applyStimulus(0, 1, 0, 0, 0, '0);
        end

        // Empty queue with simultaneous push and pop, then underflow and clear.
        applyStimulus(1, 1, 0, 0, 0, mk(50, 51, 52, 53, 6));
        checkVal("emptyPPCount", longint'(count), 1);
        checkVal("emptyPPHead", longint'(out_start_x), 50);
`ifdef LINE_QUEUE_ERR_EN
        checkVal("emptyPPUdf", longint'(udf), 0);
`endif
        applyStimulus(0, 1, 0, 0, 0, '0);
        applyStimulus(0, 1, 0, 0, 0, '0);
`ifdef LINE_QUEUE_ERR_EN
        checkVal("udfSet", longint'(udf), 1);
`endif
        applyStimulus(0, 0, 0, 1, 0, '0);
`ifdef LINE_QUEUE_ERR_EN
        checkVal("udfClr", longint'(udf), 0);
        checkVal("ovfClr", longint'(ovf), 0);
`endif

        // Alternating push/pop wraps the pointers several times.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 0, 0, 0, mk(300 + i, i, 2 * i, 3 * i, i % 8));
            checkVal("altCount", longint'(count), 1);
            checkVal("altHead", longint'(out_start_x), 300 + i);
            applyStimulus(0, 1, 0, 0, 0, '0);
        end

        // Flush beats push and pop; reset mid-stream clears everything.
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, mk(400 + i, 1, 1, 1, 1));
        checkVal("preFlushCount", longint'(count), 5);
        applyStimulus(1, 1, 1, 0, 0, mk(500, 1, 1, 1, 1));
        checkVal("flushCount", longint'(count), 0);
        checkVal("flushEmpty", longint'(empty), 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, mk(600 + i, 9, 9, 9, 3));
        applyStimulus(1, 1, 1, 0, 1, mk(700, 1, 1, 1, 1));
        checkVal("midRstCount", longint'(count), 0);
        checkVal("midRstOut", longint'({out_start_x, out_start_y, out_end_x, out_end_y, out_color}), 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            pushPct = ((i / 100) % 2 == 0) ? 70 : 30;
            applyStimulus($urandom_range(0, 99) < pushPct,
                          $urandom_range(0, 99) < 100 - pushPct,
                          $urandom_range(0, 59) == 0,
                          $urandom_range(0, 49) == 0,
                          $urandom_range(0, 199) == 0,
                          entry_t'({$urandom(), $urandom()}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/line_queue.md
LINE_QUEUE -- requirements
Module: line_queue

Interface
REQ-001 SHALL have parameter COORD_W, default 11, width of each coordinate field.
REQ-002 SHALL have parameter COLOR_W, default 3, width of the colour field.
REQ-003 SHALL have parameter DEPTH, default 8, number of entries; power of two, at least 2.
REQ-004 SHALL have parameter AFULL_LVL, default DEPTH-2, occupancy at which almost_full asserts.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port push, input, 1, write request for one line segment this cycle.
REQ-008 SHALL have ports in_start_x, in_start_y, in_end_x, in_end_y, input, COORD_W each, segment endpoints.
REQ-009 SHALL have port in_color, input, COLOR_W, segment colour.
REQ-010 SHALL have port pop, input, 1, read acknowledge; consumes the head entry.
REQ-011 SHALL have port flush, input, 1, discards all entries.
REQ-012 SHALL have ports out_start_x, out_start_y, out_end_x, out_end_y (COORD_W each) and out_color (COLOR_W), outputs, head entry, first-word-fall-through.
REQ-013 SHALL have ports empty, full, almost_full, outputs, 1 each, status flags.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-015 SHALL present the oldest stored entry on out_* combinationally from storage, with no read latency.
REQ-016 SHALL accept push when not full; data is visible on out_* the cycle after the write if the queue was empty.
REQ-017 SHALL drop push when full and pop is low; storage, pointers and count stay unchanged.
REQ-018 SHALL advance the read pointer on pop when not empty; pop when empty is ignored.
REQ-019 SHALL accept push with simultaneous pop when full; count stays DEPTH.
REQ-020 SHALL, on simultaneous push and pop when empty, write the entry and ignore the pop; count becomes 1; no bypass.
REQ-021 SHALL, on simultaneous push and pop otherwise, write and read with count unchanged.
REQ-022 SHALL wrap both pointers modulo DEPTH.
REQ-023 SHALL drive status flags as follows:
- empty = (count==0)
- full = (count==DEPTH)
- almost_full = (count>=AFULL_LVL)
REQ-024 SHALL give flush priority over push and pop; the next cycle has pointers 0, count 0, empty 1; storage contents are retained.
REQ-025 SHALL treat out_* as stale while empty; the consumer uses empty to qualify the data.

Reset
REQ-026 SHALL, while rst is high at a clock edge, clear pointers, count and all storage to 0.
REQ-027 SHALL give empty=1, full=0, almost_full=0 (for AFULL_LVL>0), count=0 and out_*=0 after reset.
REQ-028 SHALL ignore push, pop and flush while rst is high; reset mid-stream discards all entries.

Configuration
REQ-029 SHALL, when macro LINE_QUEUE_ERR_EN is defined, add the following ports:
- input err_clr (1)
- output ovf (1, sticky)
- output udf (1, sticky)
- output drop_cnt (8)
REQ-030 SHALL, with LINE_QUEUE_ERR_EN defined, on a push dropped per REQ-017, set ovf and increment drop_cnt, saturating at 255.
REQ-031 SHALL, with LINE_QUEUE_ERR_EN defined, set udf on a pop while empty, excluding a pop that accompanies a push on an empty queue.
REQ-032 SHALL, with LINE_QUEUE_ERR_EN defined, clear ovf, udf and drop_cnt on rst or err_clr; on the same cycle, err_clr takes priority over a new error event.
REQ-033 SHALL, without LINE_QUEUE_ERR_EN, omit those ports and logic; all other behaviour is identical.

Verification (defaults, LINE_QUEUE_ERR_EN defined)
REQ-034 SHALL cover: reset, then push (10,20,30,40,c=5) -> next cycle empty=0, count=1, out=(10,20,30,40,5); pop -> empty=1.
REQ-035 SHALL cover: 8 pushes of x=0..7 -> full=1, almost_full asserted from count 6; 9th push -> dropped, ovf=1, drop_cnt=1; 8 pops -> out_start_x reads 0..7 in order.
REQ-036 SHALL cover: full queue plus push and pop in one cycle -> count stays 8, new entry read last, ovf unchanged.
REQ-037 SHALL cover: empty queue plus push and pop in one cycle -> count=1, udf=0; pop while empty alone -> udf=1; err_clr -> udf=0.
REQ-038 SHALL cover: 20 alternating push/pop cycles -> pointers wrap, FIFO order is held and count stays at most 1.
REQ-039 SHALL cover: count=5 with flush, push and pop asserted together -> next cycle count=0, empty=1; rst asserted at count=3 -> next cycle count=0, out_*=0.
